sram_addr_sequencer: RTL

Parametrised address sequencer for the SRAM test datapath: produces the address stream that the test controller writes and reads back. It supports ascending, descending, strided and walking-ones sweeps over a programmable inclusive window, with start/advance/done handshaking. Addresses are registered and presented one per `next_addr` acknowledgement.

---
 rtl/sram_addr_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sram_addr_sequencer.sv
// Address sequencer for the SRAM test datapath: up/down/strided and walking-ones/zeros sweeps.
// Optional pass counter output enabled by defining SRAM_ADDR_SEQ_PASS_CNT_EN.
module sram_addr_sequencer #(
    parameter int ADDR_BITS   = 20,
    parameter int STRIDE_BITS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [ADDR_BITS-1:0]   base_addr,
    input  logic [ADDR_BITS-1:0]   end_addr,
    input  logic [STRIDE_BITS-1:0] stride,
    input  logic                   next_addr,
    output logic [ADDR_BITS-1:0]   addr,
    output logic                   addr_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err,
`ifdef SRAM_ADDR_SEQ_PASS_CNT_EN
    output logic [15:0]            pass_count,
`endif
    output logic [1:0]             state_dbg
);

    // Handshake: addr is accepted on a rising edge where addr_valid && next_addr;
    // the following address (or done) appears after that same edge.
    // start wins over next_addr and is honoured in every state.

    localparam int W = ((ADDR_BITS > STRIDE_BITS) ? ADDR_BITS : STRIDE_BITS) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [ADDR_BITS-1:0]   base_q, base_d;
    logic [ADDR_BITS-1:0]   end_q, end_d;
    logic [STRIDE_BITS-1:0] stride_q, stride_d;
    logic [1:0]             mode_q, mode_d;
    logic                   addr_valid_q, addr_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   cfg_err_q, cfg_err_d;
`ifdef SRAM_ADDR_SEQ_PASS_CNT_EN
    logic [15:0]            pass_count_q, pass_count_d;
`endif

    // Wide arithmetic so carry and borrow are visible instead of wrapping.
    logic [W-1:0]           addr_w, stride_w, sum_w, diff_w;
    logic                   borrow;
    logic                   is_last;
    logic [ADDR_BITS-1:0]   step_addr;
    logic [ADDR_BITS-1:0]   rot_addr;

    always_comb begin
        addr_w    = W'(addr_q);
        stride_w  = W'(stride_q);
        sum_w     = addr_w + stride_w;
        diff_w    = addr_w - stride_w;
        borrow    = (stride_w > addr_w);
        rot_addr  = {addr_q[ADDR_BITS-2:0], addr_q[ADDR_BITS-1]};
        is_last   = 1'b0;
        step_addr = addr_q;
        case (mode_q)
            2'd0: begin
                is_last   = (sum_w > W'(end_q));
                step_addr = sum_w[ADDR_BITS-1:0];
            end
            2'd1: begin
                is_last   = borrow || (diff_w < W'(base_q));
                step_addr = diff_w[ADDR_BITS-1:0];
            end
            2'd2: begin
                is_last   = addr_q[ADDR_BITS-1];
                step_addr = rot_addr;
            end
            default: begin
                is_last   = ~addr_q[ADDR_BITS-1];
                step_addr = rot_addr;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        base_d       = base_q;
        end_d        = end_q;
        stride_d     = stride_q;
        mode_d       = mode_q;
        addr_valid_d = addr_valid_q;
        busy_d       = busy_q;
        done_d       = done_q;
        cfg_err_d    = cfg_err_q;
`ifdef SRAM_ADDR_SEQ_PASS_CNT_EN
        pass_count_d = pass_count_q;
`endif
        if (start) begin
            mode_d    = mode;
            base_d    = base_addr;
            end_d     = end_addr;
            stride_d  = (stride == '0) ? STRIDE_BITS'(1) : stride;
            done_d    = 1'b0;
            cfg_err_d = 1'b0;
            if (!mode[1] && (base_addr > end_addr)) begin
                // Empty window: finish immediately, addr left as it was.
                state_d      = S_DONE;
                addr_valid_d = 1'b0;
                busy_d       = 1'b0;
                done_d       = 1'b1;
                cfg_err_d    = 1'b1;
            end else begin
                state_d      = S_RUN;
                addr_valid_d = 1'b1;
                busy_d       = 1'b1;
                case (mode)
                    2'd0:    addr_d = base_addr;
                    2'd1:    addr_d = end_addr;
                    2'd2:    addr_d = ADDR_BITS'(1);
                    default: addr_d = ~ADDR_BITS'(1);
                endcase
            end
        end else if ((state_q == S_RUN) && next_addr) begin
            if (is_last) begin
                state_d      = S_DONE;
                addr_valid_d = 1'b0;
                busy_d       = 1'b0;
                done_d       = 1'b1;
`ifdef SRAM_ADDR_SEQ_PASS_CNT_EN
                if (pass_count_q != 16'hFFFF) pass_count_d = pass_count_q + 16'd1;
`endif
            end else begin
                addr_d = step_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            base_q       <= '0;
            end_q        <= '0;
            stride_q     <= '0;
            mode_q       <= 2'd0;
            addr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
`ifdef SRAM_ADDR_SEQ_PASS_CNT_EN
            pass_count_q <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            base_q       <= base_d;
            end_q        <= end_d;
            stride_q     <= stride_d;
            mode_q       <= mode_d;
            addr_valid_q <= addr_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
`ifdef SRAM_ADDR_SEQ_PASS_CNT_EN
            pass_count_q <= pass_count_d;
`endif
        end
    end

    assign addr       = addr_q;
    assign addr_valid = addr_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;
    assign state_dbg  = state_q;
`ifdef SRAM_ADDR_SEQ_PASS_CNT_EN
    assign pass_count = pass_count_q;
`endif

endmodule
